lockout_timer: RTL and testbench
================================

// Module: lockout_timer
// PURPOSE
//  Downstream of the 3-failed-attempt checker: consumes its clk_enb trip flag and
//  enforces a timed keypad lockout with escalating duration. Drives the keypad
//  inhibit, an alarm blink LED and a seconds-remaining count for the display,
//  then pulses attempt_clr to reset the attempt checker when the lockout ends.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per 1 s tick (use small values in sim)
//  LOCK_SEC  30           first lockout duration, seconds (1..MAX_SEC)
//  MAX_SEC   240          escalation cap, seconds (<=255)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  clk_enb      in   1  trip level from attempt checker (high = 3 failures)
//  pass_ok      in   1  1-cycle pulse: correct password accepted
//  admin_unlock in   1  1-cycle pulse: supervisor override, aborts lockout
//  lock_active  out  1  keypad inhibit; high whole lockout
//  alarm_led    out  1  toggles every tick while locked, 0 otherwise
//  attempt_clr  out  1  1-cycle pulse: clear attempt checker counter
//  sec_left     out  8  seconds remaining, 0 when idle
//  level        out  2  escalation level 0..3
// BEHAVIOUR
//  Reset: state IDLE; lock_active=0, alarm_led=0, attempt_clr=0, sec_left=0,
//   level=0, prescaler=0, clk_enb_q=0. Reset mid-lockout aborts, no attempt_clr.
//  All outputs registered. trip = clk_enb & ~clk_enb_q (rising edge only; a level
//   held high does not re-trip).
//  States IDLE, LOCKED, RELEASE.
//  IDLE: trip -> LOCKED next cycle: sec_left = min(LOCK_SEC<<level, MAX_SEC),
//   prescaler=0, lock_active=1, alarm_led=1. pass_ok (no trip same cycle) -> level=0.
//   trip and pass_ok same cycle: trip wins, level unchanged.
//  LOCKED: prescaler counts 0..TICK_DIV-1; tick when ==TICK_DIV-1, then wraps to 0.
//   On tick: alarm_led toggles; if sec_left==1 -> RELEASE, sec_left=0; else
//   sec_left-=1. trip and pass_ok ignored. admin_unlock -> RELEASE immediately
//   (same priority slot as expiry; admin_unlock wins over tick), level unchanged.
//  RELEASE (exactly 1 cycle): attempt_clr=1, lock_active=0, alarm_led=0,
//   sec_left=0; level = sat(level+1, 3) on expiry, unchanged on admin_unlock;
//   -> IDLE. attempt_clr low in all other cycles.
//  Lockout length: trip-detect cycle to RELEASE = 1 + sec*TICK_DIV cycles.
//  Level saturates at 3; duration saturates at MAX_SEC (30,60,120,240 default).
//  clk_enb still high after RELEASE (checker clears one cycle later) must not
//   re-trip: clk_enb_q tracks input every cycle in every state.
// TESTING
//  rst; TICK_DIV=4; raise clk_enb -> lock_active=1 next cycle, sec_left=30,
//   decrements every 4 cycles, attempt_clr single pulse after 120 cycles, level=1.
//  Four successive trips (each clk_enb low then high) -> sec_left loads 30,60,120,
//   240, fifth trip 240 again; level sticks at 3.
//  pass_ok in IDLE with level=2 -> level=0; next trip loads 30.
//  admin_unlock at sec_left=17 -> RELEASE next cycle, attempt_clr pulse, level kept.
//  Hold clk_enb high through RELEASE -> no second lockout; lock_active stays 0.
//  rst asserted mid-LOCKED -> all outputs 0 next cycle, no attempt_clr pulse.

Source files
------------

// File: rtl/lockout_timer.sv
// lockout_timer: timed keypad lockout with escalating duration.
// A rising edge on clk_enb starts a lockout. Its length starts at LOCK_SEC
// and doubles with each escalation level, capped at MAX_SEC. When the lockout
// ends, by expiry or by supervisor override, the block spends one RELEASE
// cycle pulsing attempt_clr. All outputs come straight from registers.
module lockout_timer #(
   parameter int TICK_DIV = 100_000_000,
   parameter int LOCK_SEC = 30,
   parameter int MAX_SEC  = 240
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_enb,
   input  logic       pass_ok,
   input  logic       admin_unlock,
   output logic       lock_active,
   output logic       alarm_led,
   output logic       attempt_clr,
   output logic [7:0] sec_left,
   output logic [1:0] level
);

   localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCKED  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [PW-1:0] prescaler, prescaler_n;
   logic          clk_enb_q;
   logic          trip, tick;
   logic          lock_n, alarm_n, clr_n;
   logic [7:0]    sec_n;
   logic [1:0]    level_n;
   logic [31:0]   dur_raw;
   logic [7:0]    load_sec;

   // A level that stays high must not re-trip, so only the rising edge counts.
   assign trip = clk_enb & ~clk_enb_q;
   assign tick = (prescaler == TICK_MAX);

   // Lockout length for the current level, clamped to the escalation cap.
   always_comb begin
      dur_raw  = 32'(LOCK_SEC) << level;
      load_sec = (dur_raw > 32'(MAX_SEC)) ? 8'(MAX_SEC) : dur_raw[7:0];
   end

   // Next state and next register values for all outputs.
   always_comb begin
      state_n     = state;
      prescaler_n = prescaler;
      lock_n      = lock_active;
      alarm_n     = alarm_led;
      clr_n       = 1'b0;
      sec_n       = sec_left;
      level_n     = level;
      case (state)
         IDLE: begin
            prescaler_n = '0;
            lock_n      = 1'b0;
            alarm_n     = 1'b0;
            sec_n       = 8'd0;
            if (trip) begin
               // A trip wins over pass_ok arriving in the same cycle.
               state_n = LOCKED;
               sec_n   = load_sec;
               lock_n  = 1'b1;
               alarm_n = 1'b1;
            end else if (pass_ok) begin
               level_n = 2'd0;
            end
         end
         LOCKED: begin
            if (admin_unlock) begin
               // Override ends the lockout without escalating the level.
               state_n     = RELEASE;
               prescaler_n = '0;
               lock_n      = 1'b0;
               alarm_n     = 1'b0;
               clr_n       = 1'b1;
               sec_n       = 8'd0;
            end else if (tick) begin
               prescaler_n = '0;
               if (sec_left <= 8'd1) begin
                  state_n = RELEASE;
                  lock_n  = 1'b0;
                  alarm_n = 1'b0;
                  clr_n   = 1'b1;
                  sec_n   = 8'd0;
                  level_n = (level == 2'd3) ? 2'd3 : level + 2'd1;
               end else begin
                  sec_n   = sec_left - 8'd1;
                  alarm_n = ~alarm_led;
               end
            end else begin
               prescaler_n = prescaler + PW'(1);
            end
         end
         RELEASE: begin
            state_n     = IDLE;
            prescaler_n = '0;
            lock_n      = 1'b0;
            alarm_n     = 1'b0;
            sec_n       = 8'd0;
         end
         default: begin
            state_n     = IDLE;
            prescaler_n = '0;
            lock_n      = 1'b0;
            alarm_n     = 1'b0;
            sec_n       = 8'd0;
         end
      endcase
   end

   // State, prescaler, edge detector and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         prescaler   <= '0;
         clk_enb_q   <= 1'b0;
         lock_active <= 1'b0;
         alarm_led   <= 1'b0;
         attempt_clr <= 1'b0;
         sec_left    <= 8'd0;
         level       <= 2'd0;
      end else begin
         state       <= state_n;
         prescaler   <= prescaler_n;
         clk_enb_q   <= clk_enb;
         lock_active <= lock_n;
         alarm_led   <= alarm_n;
         attempt_clr <= clr_n;
         sec_left    <= sec_n;
         level       <= level_n;
      end
   end

endmodule

// File: tb/tb_lockout_timer.sv
// tb_lockout_timer: randomized lockout scenarios checked against a
// cycle-count reference model through an expected queue.
module tb_lockout_timer;

   localparam int TB_TICK = 4;

   logic       clk = 1'b0;
   logic       rst, clk_enb, pass_ok, admin_unlock;
   logic       lock_active, alarm_led, attempt_clr;
   logic [7:0] sec_left;
   logic [1:0] level;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit mon_en  = 1'b0;
   int model_level = 0;

   // Entry: {start_cycle[31:0], release_k[15:0], load[7:0], lvl_before[1:0],
   //         lvl_after[1:0], kind[1:0]}; kind 0 expiry, 1 admin, 2 reset.
   logic [61:0] exp_q[$];
   logic [61:0] cur;
   bit          in_lock = 1'b0;
   int          mk = 0;
   int          m_rel, m_sec;
   bit          m_alarm;

   lockout_timer #(.TICK_DIV(TB_TICK), .LOCK_SEC(30), .MAX_SEC(240)) dut (
      .clk(clk), .rst(rst), .clk_enb(clk_enb), .pass_ok(pass_ok),
      .admin_unlock(admin_unlock), .lock_active(lock_active),
      .alarm_led(alarm_led), .attempt_clr(attempt_clr),
      .sec_left(sec_left), .level(level)
   );

   // Clock, cycle counter and run-length guard.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      if (cyc > 60000) begin
         $display("FAIL watchdog: cycle %0d exceeded budget 60000", cyc);
         $fatal(1, "watchdog");
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Lockout seconds: LOCK_SEC doubled per level, capped at MAX_SEC.
   function automatic int ref_load(input int lvl);
      int d;
      d = 30 * (2 ** lvl);
      return (d > 240) ? 240 : d;
   endfunction

   // Monitor: pops an entry when its lockout is due and follows it cycle by cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (!in_lock && exp_q.size() > 0 && cyc == int'(exp_q[0][61:30])) begin
            cur     = exp_q.pop_front();
            in_lock = 1'b1;
            mk      = 0;
            check("lock_start", 64'(lock_active), 64'd1);
         end
         if (in_lock) begin
            m_rel = int'(cur[29:14]);
            if (mk < m_rel) begin
               m_sec   = int'(cur[13:6]) - mk / TB_TICK;
               m_alarm = ((mk / TB_TICK) % 2) == 0;
               check("lock_cycle",
                     64'({lock_active, attempt_clr, alarm_led, sec_left, level}),
                     64'({1'b1, 1'b0, m_alarm, 8'(m_sec), cur[5:4]}));
            end else begin
               check("release",
                     64'({lock_active, attempt_clr, alarm_led, sec_left, level}),
                     64'({1'b0, (cur[1:0] != 2'd2), 1'b0, 8'd0, cur[3:2]}));
               in_lock = 1'b0;
            end
            mk++;
         end else begin
            check("idle_out", 64'({lock_active, attempt_clr, alarm_led, sec_left}), 64'd0);
         end
      end
   end

   // Idle cycles with clk_enb low; optional pass_ok and ignored admin pulses.
   task automatic idle_gap(input int n, input bit force_pass, input bit rand_pass);
      for (int i = 0; i < n; i++) begin
         clk_enb      = 1'b0;
         pass_ok      = (force_pass && i == 0) || (rand_pass && $urandom_range(0, 5) == 0);
         admin_unlock = ($urandom_range(0, 7) == 0);
         if (pass_ok) model_level = 0;
         step();
      end
      pass_ok      = 1'b0;
      admin_unlock = 1'b0;
   endtask

   // One lockout: trip, lock with noise on ignored inputs, end by kind.
   task automatic run_lockout(input int kind, input int sel_at, input bit pass_same, input bit hold);
      int load, k_rel, lvl_after, g, at;
      load = ref_load(model_level);
      at   = 0;
      if (kind == 0) begin
         k_rel     = load * TB_TICK;
         lvl_after = (model_level < 3) ? model_level + 1 : 3;
      end else begin
         at        = (sel_at >= 0) ? sel_at : int'($urandom_range(0, load * TB_TICK - 1));
         k_rel     = at + 1;
         lvl_after = (kind == 1) ? model_level : 0;
      end
      g = -1;
      if (k_rel >= 4 && $urandom_range(0, 1) == 1) g = int'($urandom_range(0, k_rel - 3));
      clk_enb = 1'b1;
      pass_ok = pass_same;
      exp_q.push_back({32'(cyc + 1), 16'(k_rel), 8'(load), 2'(model_level), 2'(lvl_after), 2'(kind)});
      step();
      for (int k = 0; k < k_rel; k++) begin
         admin_unlock = (kind == 1 && k == k_rel - 1);
         rst          = (kind == 2 && k == k_rel - 1);
         clk_enb      = rst ? 1'b0 : (k != g);
         pass_ok      = ($urandom_range(0, 7) == 0);
         step();
      end
      admin_unlock = 1'b0;
      rst          = 1'b0;
      pass_ok      = 1'b0;
      model_level  = lvl_after;
      if (kind != 2) begin
         step();
         if (hold) repeat (5) step();
         clk_enb = 1'b0;
      end
   endtask

   initial begin
      int kind;
      rst = 1'b1;
      clk_enb = 1'b0;
      pass_ok = 1'b0;
      admin_unlock = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      check("reset_state", 64'({lock_active, attempt_clr, alarm_led, sec_left, level}), 64'd0);
      mon_en = 1'b1;
      idle_gap(2, 1'b0, 1'b0);

      // Escalation 30, 60, 120, 240, 240.
      for (int i = 0; i < 5; i++) begin
         run_lockout(0, -1, 1'b0, 1'b0);
         idle_gap(int'($urandom_range(1, 3)), 1'b0, 1'b0);
         check("level_esc", 64'(level), 64'(model_level));
      end
      // pass_ok clears level, then escalate to 2 and clear again.
      idle_gap(2, 1'b1, 1'b0);
      check("level_pass", 64'(level), 64'(model_level));
      run_lockout(0, -1, 1'b0, 1'b0);
      idle_gap(2, 1'b0, 1'b0);
      run_lockout(0, -1, 1'b0, 1'b0);
      idle_gap(2, 1'b0, 1'b0);
      check("level_two", 64'(level), 64'(model_level));
      idle_gap(2, 1'b1, 1'b0);
      check("level_clr", 64'(level), 64'(model_level));
      // Override when sec_left reads 17.
      run_lockout(1, (30 - 17) * TB_TICK, 1'b0, 1'b0);
      idle_gap(2, 1'b0, 1'b0);
      check("level_admin", 64'(level), 64'(model_level));
      // clk_enb held through RELEASE must not relock.
      run_lockout(0, -1, 1'b0, 1'b1);
      idle_gap(2, 1'b0, 1'b0);
      // Reset mid-lockout, with pass_ok coinciding with the trip.
      run_lockout(2, -1, 1'b1, 1'b0);
      idle_gap(2, 1'b0, 1'b0);
      check("level_rst", 64'(level), 64'(model_level));

      // Random mix.
      for (int it = 0; it < 16; it++) begin
         kind = int'($urandom_range(0, 9));
         kind = (kind < 3) ? 0 : (kind < 7) ? 1 : 2;
         run_lockout(kind, -1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
         idle_gap(int'($urandom_range(1, 4)), 1'b0, 1'b1);
         check("level_rand", 64'(level), 64'(model_level));
      end

      repeat (8) step();
      check("drain_queue", 64'(exp_q.size()), 64'd0);
      check("drain_lock", 64'(in_lock), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
